// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and constants for the SRAM burst reader slice.
//   rd_state_e  : burst reader FSM states
//   SKID_DEPTH  : entries in the read-return buffer (covers the 1-cycle SRAM
//                 latency plus one word of downstream backpressure)
//   credit_ok() : issue gate -- true when a new read still has a buffer slot
// -----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam int SKID_DEPTH = 2;

  // Words already held plus the read in flight, minus the word leaving this
  // cycle, must stay below the buffer depth so the returning word always fits.
  // A pop only happens when occ >= 1, so the subtraction cannot underflow.
  function automatic logic credit_ok(input logic [1:0] occ,
                                     input logic       rd_pend,
                                     input logic       pop);
    logic [2:0] in_flight;
    in_flight = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
    return in_flight < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/sram_rd_skid.sv
// -----------------------------------------------------------------------------
// sram_rd_skid
// Two-entry synchronous FIFO holding {data, last} for words returned by the
// SRAM. Head entry is presented combinationally so it stays stable while the
// consumer stalls.
// Ports:
//   clk, rst            clock / synchronous active-high reset (flushes FIFO)
//   push, push_data,
//   push_last           write one word (caller guarantees not full)
//   pop                 remove head word (caller guarantees not empty)
//   out_data, out_last  head word
//   occ                 current occupancy 0..2
// -----------------------------------------------------------------------------
module sram_rd_skid
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] data_reg [SKID_DEPTH];
  logic [SKID_DEPTH-1:0] last_reg;
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            occ_reg;

  // Storage entries carry no reset: validity is tracked by occ_reg alone.
  for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == 1'(gi))) begin
        data_reg[gi] <= push_data;
        last_reg[gi] <= push_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign out_data = data_reg[rd_ptr_reg];
  assign out_last = last_reg[rd_ptr_reg];
  assign occ      = occ_reg;

endmodule

// File: rtl/sram_burst_reader.sv
// -----------------------------------------------------------------------------
// sram_burst_reader
// Read-side initiator for a single-port synchronous SRAM. On start it fetches
// len words from base_addr (wrapping modulo DEPTH) and streams them out on a
// valid/ready interface with a last flag, hiding the SRAM's 1-cycle read
// latency and absorbing backpressure at up to one word per cycle.
// Ports:
//   clk, rst               clock / synchronous active-high reset
//   start, base_addr, len  burst request, sampled only in IDLE (len 0 = empty)
//   busy                   high from the cycle after an accepted start until
//                          the done cycle (inclusive)
//   done                   one-cycle pulse at the end of every burst
//   sram_csb, sram_wsb,
//   sram_raddr, sram_rdata SRAM read port (csb active-low, wsb tied high)
//   m_valid, m_ready,
//   m_data, m_last         output stream
//   perf_stall_cnt         only with SRAM_READER_PERF_EN defined: saturating
//                          count of m_valid & !m_ready cycles since the last
//                          reset or accepted start
// Build option: SRAM_READER_PERF_EN adds the stall counter and its port.
// -----------------------------------------------------------------------------
module sram_burst_reader
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_csb,
  output logic                  sram_wsb,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef SRAM_READER_PERF_EN
  output logic [31:0]           perf_stall_cnt,
`endif
  output logic                  m_last
);

  localparam int LW = ADDR_WIDTH + 1;

  rd_state_e             state_reg;
  rd_state_e             state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;       // next address to issue
  logic [ADDR_WIDTH-1:0] raddr_reg;      // last issued address
  logic [LW-1:0]         len_reg;
  logic [LW-1:0]         issue_cnt_reg;  // reads issued this burst
  logic [LW-1:0]         ret_cnt_reg;    // words returned into the buffer
  logic                  rd_pend_reg;    // SRAM read data arrives this cycle

  logic                  start_ok;
  logic                  pop;
  logic                  issue;
  logic                  push_last;
  logic [1:0]            occ;

  assign start_ok = (state_reg == IDLE) && start;
  assign pop      = m_valid && m_ready;

  // Issue decision depends on this cycle's pop, so m_ready reaches sram_csb
  // combinationally; that is what lets the reader sustain one word per cycle
  // with only two buffer entries. Reset suppresses any issue in its own cycle
  // so an aborted burst never touches the SRAM again.
  assign issue = !rst
              && (state_reg == RUN)
              && (issue_cnt_reg != len_reg)
              && credit_ok(occ, rd_pend_reg, pop);

  assign sram_csb   = !issue;
  assign sram_wsb   = 1'b1;
  assign sram_raddr = issue ? addr_reg : raddr_reg;

  assign push_last = (ret_cnt_reg == (len_reg - LW'(1)));

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign m_valid = (occ != 2'd0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue && ((issue_cnt_reg + LW'(1)) == len_reg)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Last read has returned and the last word has left the buffer.
        if (!rd_pend_reg && (occ == 2'd0)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      raddr_reg     <= '0;
      len_reg       <= '0;
      issue_cnt_reg <= '0;
      ret_cnt_reg   <= '0;
      rd_pend_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_pend_reg <= issue;
      if (start_ok) begin
        addr_reg      <= base_addr;
        len_reg       <= len;
        issue_cnt_reg <= '0;
        ret_cnt_reg   <= '0;
      end
      if (issue) begin
        // Natural wrap of the address counter gives modulo-DEPTH addressing.
        addr_reg      <= addr_reg + ADDR_WIDTH'(1);
        raddr_reg     <= addr_reg;
        issue_cnt_reg <= issue_cnt_reg + LW'(1);
      end
      if (rd_pend_reg) begin
        ret_cnt_reg <= ret_cnt_reg + LW'(1);
      end
    end
  end

  // sram_rdata is captured only in the cycle after an issue edge.
  sram_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend_reg),
    .push_data (sram_rdata),
    .push_last (push_last),
    .pop       (pop),
    .out_data  (m_data),
    .out_last  (m_last),
    .occ       (occ)
  );

`ifdef SRAM_READER_PERF_EN
  logic [31:0] perf_stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      perf_stall_cnt_reg <= '0;
    end else if (m_valid && !m_ready && (perf_stall_cnt_reg != 32'hFFFF_FFFF)) begin
      perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_sram_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_sram_burst_reader
// Self-checking bench for sram_burst_reader: behavioural SRAM (mem[i] = i),
// a scoreboard of expected read addresses and stream words, a table of bursts
// and hand-written sequences for timing, backpressure, empty bursts, ignored
// starts and mid-burst reset.
// -----------------------------------------------------------------------------
module tb_sram_burst_reader;

  localparam int DW    = 512;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          sram_csb;
  logic          sram_wsb;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata = '0;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
`ifdef SRAM_READER_PERF_EN
  logic [31:0]   perf_stall_cnt;
`endif

  sram_burst_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .sram_csb   (sram_csb),
    .sram_wsb   (sram_wsb),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
`ifdef SRAM_READER_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: data one cycle after a csb-low edge, poison otherwise
  // so any capture at the wrong time shows up as a data error.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_csb && sram_wsb) sram_rdata <= mem[sram_raddr];
    else                       sram_rdata <= {16{32'hDEAD_BEEF}};
  end

  task automatic load_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
  endtask

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic          mon_en = 1'b1;
  int            csb_cnt = 0;
  int            done_cnt = 0;
  int            valid_cnt = 0;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (!sram_csb) begin
        csb_cnt++;
        if (addr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_read: got read at addr %0d expected no read", sram_raddr);
        end else begin
          check("raddr", DW'(sram_raddr), DW'(addr_q.pop_front()));
        end
      end
      if (m_valid) valid_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_word: got word %0h expected none", m_data);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check("m_data", m_data, w.data);
          check("m_last", DW'(m_last), DW'(w.last));
        end
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic expect_burst(input logic [AW-1:0] b, input logic [AW:0] l);
    for (int i = 0; i < int'(l); i++) begin
      word_t w;
      w.data = mem[(int'(b) + i) % DEPTH];
      w.last = (i == int'(l) - 1);
      exp_q.push_back(w);
      addr_q.push_back(AW'(int'(b) + i));
    end
    csb_cnt   = 0;
    done_cnt  = 0;
    valid_cnt = 0;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l;
    @(posedge clk); #1;
    // Scramble the request inputs so a late sample would be visible.
    start = 1'b0; base_addr = ~b; len = ~l;
  endtask

  function automatic logic ready_at(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic finish_burst(input int l, input int mode);
    for (int c = 0; c < 2000 && done_cnt == 0; c++) begin
      @(posedge clk); #1;
      m_ready = ready_at(mode, c);
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("done_pulses", DW'(done_cnt), DW'(1));
    check("reads_issued", DW'(csb_cnt), DW'(l));
    check("words_left", DW'(exp_q.size()), DW'(0));
    check("addrs_left", DW'(addr_q.size()), DW'(0));
    check("busy_after", DW'(busy), DW'(0));
  endtask

  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l, input int mode);
    expect_burst(b, l);
    m_ready = ready_at(mode, 0);
    do_start(b, l);
    finish_burst(int'(l), mode);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;   // 0 ready=1, 1 toggle 1010.., 2 random
    logic [AW-1:0] hold;   // sram_raddr expected once idle again
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{base: 6'd62, len: 7'd4,   mode: 0, hold: 6'd1};
    tbl[1] = '{base: 6'd10, len: 7'd6,   mode: 1, hold: 6'd15};
    tbl[2] = '{base: 6'd0,  len: 7'd64,  mode: 2, hold: 6'd63};
    tbl[3] = '{base: 6'd33, len: 7'd100, mode: 0, hold: 6'd4};
    tbl[4] = '{base: 6'd7,  len: 7'd1,   mode: 1, hold: 6'd7};
    tbl[5] = '{base: 6'd50, len: 7'd127, mode: 2, hold: 6'd48};

    load_mem();
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   DW'(busy),       DW'(0));
    check("rst_done",   DW'(done),       DW'(0));
    check("rst_csb",    DW'(sram_csb),   DW'(1));
    check("rst_wsb",    DW'(sram_wsb),   DW'(1));
    check("rst_raddr",  DW'(sram_raddr), DW'(0));
    check("rst_mvalid", DW'(m_valid),    DW'(0));
    check("rst_mlast",  DW'(m_last),     DW'(0));
    rst = 1'b0;

    // Throughput: base 4 len 8, first word 2 cycles after start, no bubbles.
    expect_burst(6'd4, 7'd8);
    m_ready = 1'b1;
    do_start(6'd4, 7'd8);
    @(posedge clk); #1;
    check("tp_valid_early", DW'(m_valid), DW'(0));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("tp_valid", DW'(m_valid), DW'(1));
      check("tp_data",  m_data, DW'(4 + i));
      check("tp_last",  DW'(m_last), DW'(i == 7));
    end
    finish_burst(8, 0);

    // Backpressure: ready low for 10 cycles, only two reads may be issued.
    expect_burst(6'd20, 7'd5);
    m_ready = 1'b0;
    do_start(6'd20, 7'd5);
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("stall_reads",  DW'(csb_cnt), DW'(2));
    check("stall_valid",  DW'(m_valid), DW'(1));
    check("stall_data",   m_data, DW'(20));
    m_ready = 1'b1;
    finish_burst(5, 0);

    // Start while busy is ignored.
    expect_burst(6'd30, 7'd3);
    m_ready = 1'b1;
    do_start(6'd30, 7'd3);
    start = 1'b1; base_addr = 6'd40; len = 7'd10;
    @(posedge clk); #1;
    start = 1'b0;
    finish_burst(3, 0);

    // Empty burst, plus a start during the DONE cycle that must be ignored.
    expect_burst(6'd5, 7'd0);
    do_start(6'd5, 7'd0);
    check("empty_busy", DW'(busy), DW'(1));
    start = 1'b1; base_addr = 6'd9; len = 7'd3;
    @(posedge clk); #1;
    start = 1'b0;
    finish_burst(0, 0);
    check("empty_no_valid", DW'(valid_cnt), DW'(0));

    // Reset mid-burst with words buffered and a read in flight.
    mon_en = 1'b0;
    m_ready = 1'b0;
    do_start(6'd8, 7'd10);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", DW'(m_valid),  DW'(0));
    check("abort_csb",   DW'(sram_csb), DW'(1));
    check("abort_busy",  DW'(busy),     DW'(0));
    @(posedge clk); #1;
    check("abort_no_done", DW'(done), DW'(0));
    exp_q.delete();
    addr_q.delete();
    mon_en = 1'b1;
    run_burst(6'd3, 7'd5, 0);

    // Table of bursts: wrap, toggled/random ready, len > DEPTH, max len.
    for (int t = 0; t < 6; t++) begin
      run_burst(tbl[t].base, tbl[t].len, tbl[t].mode);
      check("raddr_hold", DW'(sram_raddr), DW'(tbl[t].hold));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
